// File: rtl/sdram_pkg.sv
// sdram_pkg: shared SDRAM command constants and arbiter state encoding
// Used by the arbiter and by the init, refresh, read and write controllers.
package sdram_pkg;
    localparam int CMD_W = 18;
    localparam int TO_W  = 16;
    // {cs_n, ras_n, cas_n, we_n, ba[1:0], addr[11:0]}
    localparam logic [CMD_W-1:0] NOP_CMD  = 18'h1c000;
    localparam logic [CMD_W-1:0] PALL_CMD = 18'h08400;
    localparam logic [CMD_W-1:0] REF_CMD  = 18'h04000;
    localparam logic [CMD_W-1:0] MR_CMD   = 18'h00032;
    typedef enum logic [2:0] {
        INIT  = 3'd0,
        ARBIT = 3'd1,
        AREF  = 3'd2,
        WRITE = 3'd3,
        READ  = 3'd4
    } arb_state_t;
endpackage

// File: rtl/sdram_arbit.sv
// sdram_arbit: SDRAM command-bus arbiter (init hold-off, refresh > write/read alternation)
// Ports:
//   clk, rst                   clock, async active-high reset
//   init_end_flag, init_cmd    init sequencer done flag and its command
//   ref_/wr_/rd_ req,end,cmd   requester level request, done pulse, command
//   ref_en, wr_en, rd_en       registered grants
//   sdram_cmd                  command to the pins, muxed from the state register
//   timeout_err                sticky grant-timeout flag
//   arb_state                  FSM state for debug
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter int GNT_TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init_end_flag,
    input  logic [CMD_W-1:0] init_cmd,
    input  logic             ref_req,
    input  logic             ref_end,
    input  logic [CMD_W-1:0] ref_cmd,
    input  logic             wr_req,
    input  logic             wr_end,
    input  logic [CMD_W-1:0] wr_cmd,
    input  logic             rd_req,
    input  logic             rd_end,
    input  logic [CMD_W-1:0] rd_cmd,
    output logic             ref_en,
    output logic             wr_en,
    output logic             rd_en,
    output logic [CMD_W-1:0] sdram_cmd,
    output logic             timeout_err,
    output logic [2:0]       arb_state
);
    arb_state_t      r_state, w_next;
    logic            r_ref_en, r_wr_en, r_rd_en, r_err, r_last_wr;
    logic [TO_W-1:0] r_cnt;
    logic            w_end, w_to, w_grant;
    logic [CMD_W-1:0] w_cmd;

    always_comb begin
        w_next = r_state;
        w_end  = 1'b0;
        w_cmd  = NOP_CMD;
        case (r_state)
            INIT: begin
                w_cmd  = init_cmd;
                w_next = init_end_flag ? ARBIT : INIT;
            end
            // refresh first; on a write/read tie, alternate using last_wr
            ARBIT: w_next = ref_req ? AREF :
                            (wr_req && (!rd_req || !r_last_wr)) ? WRITE :
                            rd_req ? READ : ARBIT;
            AREF: begin
                w_cmd = ref_cmd;
                w_end = ref_end;
            end
            WRITE: begin
                w_cmd = wr_cmd;
                w_end = wr_end;
            end
            READ: begin
                w_cmd = rd_cmd;
                w_end = rd_end;
            end
            default: begin
                w_cmd  = init_cmd;
                w_next = INIT;
            end
        endcase
        w_grant = (r_state == AREF) || (r_state == WRITE) || (r_state == READ);
        // an end pulse in the timeout cycle wins, so no error is flagged
        w_to = w_grant && !w_end && (r_cnt == TO_W'(GNT_TIMEOUT - 1));
        if (w_grant && (w_end || w_to))
            w_next = ARBIT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= INIT;
            r_ref_en  <= 1'b0;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_err     <= 1'b0;
            r_last_wr <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_next;
            r_ref_en  <= (w_next == AREF);
            r_wr_en   <= (w_next == WRITE);
            r_rd_en   <= (w_next == READ);
            r_err     <= r_err | w_to;
            r_last_wr <= (w_next == WRITE) ? 1'b1 : (w_next == READ) ? 1'b0 : r_last_wr;
            r_cnt     <= (w_grant && (w_next == r_state)) ? r_cnt + 1'b1 : '0;
        end
    end

    assign ref_en      = r_ref_en;
    assign wr_en       = r_wr_en;
    assign rd_en       = r_rd_en;
    assign timeout_err = r_err;
    assign sdram_cmd   = w_cmd;
    assign arb_state   = r_state;
endmodule

// File: tb/tb_sdram_arbit.sv
// tb_sdram_arbit: directed scoreboard bench for sdram_arbit
module tb_sdram_arbit;
    import sdram_pkg::*;
    localparam logic [17:0] WRC = 18'h10123;
    localparam logic [17:0] RDC = 18'h20456;

    logic clk = 1'b0, rst = 1'b1, init_end_flag = 1'b0;
    logic ref_req = 1'b0, ref_end = 1'b0, wr_req = 1'b0, wr_end = 1'b0, rd_req = 1'b0, rd_end = 1'b0;
    logic [17:0] init_cmd = PALL_CMD, ref_cmd = REF_CMD, wr_cmd = WRC, rd_cmd = RDC;
    logic ref_en, wr_en, rd_en, timeout_err;
    logic [17:0] sdram_cmd;
    logic [2:0] arb_state;
    int vectors = 0, miscompares = 0;

    typedef struct {
        string       tag;
        logic [24:0] v;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    sdram_arbit #(.GNT_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .init_end_flag(init_end_flag), .init_cmd(init_cmd),
        .ref_req(ref_req), .ref_end(ref_end), .ref_cmd(ref_cmd),
        .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd),
        .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd),
        .ref_en(ref_en), .wr_en(wr_en), .rd_en(rd_en),
        .sdram_cmd(sdram_cmd), .timeout_err(timeout_err), .arb_state(arb_state)
    );

    // f = {ref_en, wr_en, rd_en, timeout_err}
    task automatic push(input string tag, input logic [2:0] st, input logic [3:0] f, input logic [17:0] c);
        exp_t e;
        e.tag = tag;
        e.v   = {st, f, c};
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        logic [24:0] o;
        e = sb.pop_front();
        o = {arb_state, ref_en, wr_en, rd_en, timeout_err, sdram_cmd};
        vectors++;
        assert (o === e.v) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", e.tag, o, e.v);
        end
    endtask

    task automatic chk(input string tag, input logic [2:0] st, input logic [3:0] f, input logic [17:0] c);
        push(tag, st, f, c);
        check();
    endtask

    task automatic cyc(input string tag, input logic [2:0] st, input logic [3:0] f, input logic [17:0] c);
        push(tag, st, f, c);
        @(posedge clk);
        #1;
        check();
    endtask

    // g: 2 refresh, 3 write, 4 read; request must already be high in ARBIT
    task automatic burst(input string tag, input int g, input int hold, input logic e, input logic keep);
        logic [3:0]  f;
        logic [17:0] c;
        f = (g == 2) ? {3'b100, e} : (g == 3) ? {3'b010, e} : {3'b001, e};
        c = (g == 2) ? REF_CMD : (g == 3) ? WRC : RDC;
        cyc(tag, 3'(g), f, c);
        if (!keep) begin
            if (g == 2) ref_req = 1'b0;
            else if (g == 3) wr_req = 1'b0;
            else rd_req = 1'b0;
        end
        for (int i = 1; i < hold; i++) cyc(tag, 3'(g), f, c);
        if (g == 2) ref_end = 1'b1;
        else if (g == 3) wr_end = 1'b1;
        else rd_end = 1'b1;
        cyc({tag, "_end"}, 3'd1, {3'b000, e}, NOP_CMD);
        ref_end = 1'b0;
        wr_end  = 1'b0;
        rd_end  = 1'b0;
    endtask

    initial begin
        #12;
        chk("reset", 3'd0, 4'b0000, PALL_CMD);
        wr_req = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) cyc("init_hold", 3'd0, 4'b0000, PALL_CMD);
        init_end_flag = 1'b1;
        cyc("init_done", 3'd1, 4'b0000, NOP_CMD);
        burst("init_wr", 3, 2, 1'b0, 1'b0);
        rd_req = 1'b1;
        burst("rd", 4, 2, 1'b0, 1'b0);
        // refresh beats simultaneous write/read; write follows since last grant was read
        ref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        burst("prio_ref", 2, 3, 1'b0, 1'b0);
        burst("alt_w1", 3, 8, 1'b0, 1'b1);
        burst("alt_r1", 4, 8, 1'b0, 1'b1);
        burst("alt_w2", 3, 8, 1'b0, 1'b1);
        burst("alt_r2", 4, 8, 1'b0, 1'b1);
        wr_req = 1'b0; rd_req = 1'b0;
        cyc("idle", 3'd1, 4'b0000, NOP_CMD);
        rd_end = 1'b1;
        cyc("arb_end_ignored", 3'd1, 4'b0000, NOP_CMD);
        rd_end = 1'b0;
        // timeout: 16 cycles in WRITE without wr_end
        wr_req = 1'b1;
        cyc("to_entry", 3'd3, 4'b0100, WRC);
        wr_req = 1'b0;
        repeat (15) cyc("to_hold", 3'd3, 4'b0100, WRC);
        cyc("to_fire", 3'd1, 4'b0001, NOP_CMD);
        cyc("to_sticky", 3'd1, 4'b0001, NOP_CMD);
        rd_req = 1'b1;
        burst("rd_after_to", 4, 3, 1'b1, 1'b0);
        // async reset in the middle of a read
        rd_req = 1'b1;
        cyc("rd_pre_rst", 3'd4, 4'b0011, RDC);
        rd_req = 1'b0;
        cyc("rd_pre_rst", 3'd4, 4'b0011, RDC);
        #3 rst = 1'b1;
        #1 chk("rst_async", 3'd0, 4'b0000, PALL_CMD);
        init_cmd = MR_CMD;
        #1 chk("rst_cmd_track", 3'd0, 4'b0000, MR_CMD);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_release", 3'd0, 4'b0000, MR_CMD);
        cyc("reinit", 3'd1, 4'b0000, NOP_CMD);
        // end pulse in the timeout cycle: end wins, no error
        wr_req = 1'b1;
        cyc("race_entry", 3'd3, 4'b0100, WRC);
        wr_req = 1'b0;
        repeat (15) cyc("race_hold", 3'd3, 4'b0100, WRC);
        wr_end = 1'b1;
        cyc("race_end", 3'd1, 4'b0000, NOP_CMD);
        wr_end = 1'b0;
        cyc("race_after", 3'd1, 4'b0000, NOP_CMD);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
